// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// and the legality / alignment checks used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } lsu_state_e;

    // Halfwords need an even address, words a multiple of four; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores have no unsigned variants, so they accept a narrower set of codes.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                     (funct3 == F3_BU) || (funct3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering between a memory word and sub-word accesses:
// extraction with sign/zero extension for loads, lane merge for sub-word stores.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [15:0]     wdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] merge_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the read word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (byte_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane to a full load result.
    always_comb begin
        load_val = rdata;
        case (funct3)
            F3_B:    load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_BU:   load_val = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   load_val = {{(XLEN-16){1'b0}}, half_sel};
            default: load_val = rdata;
        endcase
    end

    // Overlay the store byte/half onto the old word, leaving other lanes intact.
    always_comb begin
        merge_val = rdata;
        case (funct3)
            F3_B: begin
                case (byte_off)
                    2'd0:    merge_val[7:0]   = wdata[7:0];
                    2'd1:    merge_val[15:8]  = wdata[7:0];
                    2'd2:    merge_val[23:16] = wdata[7:0];
                    default: merge_val[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (byte_off[1]) merge_val[31:16] = wdata;
                else             merge_val[15:0]  = wdata;
            end
            default: merge_val = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request per handshake, word-aligned
// accesses to a word-only memory, read-modify-write for SB/SH, and fault
// responses for illegal or misaligned requests without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_fault,
    output logic [XLEN-1:0] load_data,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output lsu_state_e      state_dbg
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, and the request fields are
    // sampled only on that edge. resp_valid is a single-cycle pulse with no
    // backpressure; resp_fault is meaningful only while resp_valid is high.

    lsu_state_e      state_q, state_d;
    logic            accept;
    logic            req_fault;
    logic            fault_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [15:0]     wdata_q;
    logic [XLEN-1:0] merge_q;
    logic [XLEN-1:0] load_data_q;
    logic [XLEN-1:0] lane_load;
    logic [XLEN-1:0] lane_merge;

    lsu_lane #(.XLEN(XLEN)) u_lane (
        .rdata     (mem_rdata),
        .wdata     (wdata_q),
        .funct3    (funct3_q),
        .byte_off  (addr_q[1:0]),
        .load_val  (lane_load),
        .merge_val (lane_merge)
    );

    // Decide at the accept edge whether the incoming request can reach memory.
    always_comb begin
        req_fault = !is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and state-decoded strobes; every strobe is forced low in reset.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    accept = 1'b1;
                    if (req_fault)               state_d = S_RESP;
                    else if (!req_we)            state_d = S_LOAD;
                    else if (req_funct3 == F3_W) state_d = S_WRITE;
                    else                         state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                mem_read = !rst;
                state_d  = S_RESP;
            end
            S_RMW_RD: begin
                mem_read = !rst;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                mem_write = !rst;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = !rst;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, load result and store merge word.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 16'd0;
            merge_q     <= '0;
            load_data_q <= '0;
        end else begin
            if (accept) begin
                fault_q  <= req_fault;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata[15:0];
                // SW writes this directly; SB/SH overwrite it after the read.
                merge_q  <= req_wdata;
            end
            if (state_q == S_LOAD)   load_data_q <= lane_load;
            if (state_q == S_RMW_RD) merge_q     <= lane_merge;
        end
    end

    assign resp_fault = resp_valid && fault_q;
    assign load_data  = load_data_q;
    assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata  = merge_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory, directed
// scenarios followed by randomized requests, write scoreboard and summary.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_fault;
    logic [31:0] load_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    lsu_state_e  state_dbg;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:63];
    logic [7:0]  ref_bytes [0:255];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] last_load = 32'd0;
    bit          saw_read = 0;
    bit          saw_write = 0;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  st_f3 [3] = '{3'd0, 3'd1, 3'd2};

    load_store_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_fault (resp_fault),
        .load_data  (load_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .state_dbg  (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on posedge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish before 200000ns");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed) ----------------
    function automatic logic ref_fault(input logic we, input logic [2:0] f3, input int a);
        bit legal;
        int size;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return !legal || (a % size != 0);
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a - (a % 4);
        return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        longint v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = longint'(ref_bytes[a]);
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = longint'(ref_bytes[a]) + 256 * longint'(ref_bytes[a+1]);
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(ref_word(a));
        end
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] wdata);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_bytes[a+i] = 8'(wdata >> (8*i));
    endtask

    task automatic preset_word(input int w, input logic [31:0] val);
        mem[w] <= val;
        for (int i = 0; i < 4; i++) ref_bytes[4*w+i] = 8'(val >> (8*i));
    endtask

    // Bus monitor: strobe exclusivity, address shape, write scoreboard.
    always @(negedge clk) begin
        logic [31:0] ew, ea;
        #2;
        if (mem_read || mem_write) begin
            chk("rw_exclusive", {31'b0, mem_read && mem_write}, 32'd0);
            chk("mem_addr_shape", {mem_addr[31:8], 6'b0, mem_addr[1:0]}, 32'd0);
        end
        if (mem_read)  saw_read = 1;
        if (mem_write) saw_write = 1;
        if (mem_write) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_write: observed write %h at %h, expected no write", mem_wdata, mem_addr);
            end else begin
                ew = exp_q.pop_front();
                ea = exp_addr_q.pop_front();
                chk("write_data", mem_wdata, ew);
                chk("write_addr", mem_addr, ea);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int   a, lat, exp_lat;
        logic exp_fault;
        logic [31:0] exp_ld;
        bit   done;
        a = int'(addr[7:0]);
        exp_fault = ref_fault(we, f3, a);
        exp_lat   = exp_fault ? 0 : ((we && f3 != 3'd2) ? 2 : 1);
        exp_ld    = last_load;
        if (!exp_fault && !we) exp_ld = ref_load(f3, a);
        if (!exp_fault && we) begin
            ref_store(f3, a, wdata);
            exp_q.push_back(ref_word(a));
            exp_addr_q.push_back(32'(a - (a % 4)));
        end

        @(negedge clk);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        saw_read   = 0;
        saw_write  = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'($urandom_range(0, 255));
        req_wdata = $urandom;
        done = 0;
        lat  = -1;
        for (int c = 0; c < 8 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) begin
                done = 1;
                lat  = c;
            end else begin
                chk("ready_busy", {31'b0, req_ready}, 32'd0);
            end
        end
        chk("resp_seen", {31'b0, done}, 32'd1);
        chk("resp_latency", 32'(lat), 32'(exp_lat));
        chk("resp_fault", {31'b0, resp_fault}, {31'b0, exp_fault});
        chk("load_data", load_data, exp_ld);
        chk("saw_read", {31'b0, saw_read}, {31'b0, !exp_fault && !(we && f3 == 3'd2)});
        chk("saw_write", {31'b0, saw_write}, {31'b0, !exp_fault && we});
        chk("mem_word", mem[a/4], ref_word(a));
        last_load = exp_ld;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c_resp, acc_idx, r1_idx, r2_idx;
        logic [31:0] r1_data, r2_data, e1, e2;
        logic        we;
        logic [2:0]  f3;
        int          a, size;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int w = 0; w < 64; w++) preset_word(w, $urandom);
        preset_word(4, 32'h8899AABB);

        // Reset state.
        #1;
        chk("ready_in_reset", {31'b0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // Sub-word loads from 0x8899AABB.
        do_req(1'b0, F3_B, 32'h11, 32'd0);
        chk("lb_0x11", load_data, 32'hFFFFFFAA);
        do_req(1'b0, F3_BU, 32'h13, 32'd0);
        chk("lbu_0x13", load_data, 32'h00000088);
        do_req(1'b0, F3_H, 32'h10, 32'd0);
        chk("lh_0x10", load_data, 32'hFFFFAABB);
        do_req(1'b0, F3_HU, 32'h12, 32'd0);
        chk("lhu_0x12", load_data, 32'h00008899);

        // Faults.
        do_req(1'b0, F3_W, 32'h11, 32'd0);
        do_req(1'b1, F3_H, 32'h13, 32'h0000BEEF);
        do_req(1'b0, 3'd3, 32'h10, 32'd0);
        chk("fault_mem_intact", mem[4], 32'h8899AABB);

        // Reset during the WRITE cycle of SW 0x10.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h10;
        req_wdata  = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_write", 32'(state_dbg), 32'(S_WRITE));
        rst = 1'b1;
        #1;
        chk("abort_write_gated", {31'b0, mem_write}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        chk("abort_ready_low", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_resp_after", {31'b0, resp_valid}, 32'd0);
        chk("abort_mem_intact", mem[4], 32'h8899AABB);
        last_load = 32'd0;

        // Stores.
        do_req(1'b1, F3_B, 32'h12, 32'h12345677);
        chk("sb_0x12_word", mem[4], 32'h8877AABB);
        @(negedge clk);
        preset_word(4, 32'h8899AABB);
        do_req(1'b1, F3_H, 32'h10, 32'h0000CAFE);
        chk("sh_0x10_word", mem[4], 32'h8899CAFE);
        do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        chk("sw_0x10_word", mem[4], 32'hDEADBEEF);

        // Back-to-back loads with req_valid held high.
        e1 = ref_load(F3_W, 16'h10);
        e2 = ref_load(F3_BU, 16'h11);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_funct3 = F3_BU;
        req_addr   = 32'h11;
        c_resp = 0; acc_idx = -1; r1_idx = -1; r2_idx = -1;
        r1_data = 32'd0; r2_data = 32'd0;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid) begin
                c_resp++;
                if (c_resp == 1) begin r1_idx = c; r1_data = load_data; end
                if (c_resp == 2) begin r2_idx = c; r2_data = load_data; end
            end
            if (acc_idx < 0 && req_ready && req_valid) acc_idx = c;
            if (acc_idx >= 0 && c == acc_idx + 1) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_resp_count", 32'(c_resp), 32'd2);
        chk("b2b_resp1_cycle", 32'(r1_idx), 32'd1);
        chk("b2b_accept2_cycle", 32'(acc_idx), 32'd2);
        chk("b2b_resp2_cycle", 32'(r2_idx), 32'd4);
        chk("b2b_data1", r1_data, e1);
        chk("b2b_data2", r2_data, e2);
        last_load = e2;

        // Randomized requests.
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            else                           f3 = 3'($urandom_range(0, 7));
            size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a - (a % size);
            do_req(we, f3, 32'(a), $urandom);
        end

        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the execute stage and the word-only data memory. Accepts one RV32I load or store per handshake and generates word-aligned read/write strobes for the data memory. Performs byte/halfword lane extraction with sign or zero extension for loads, and read-modify-write for sub-word stores. Flags misaligned or illegal accesses instead of touching memory.

## Interface

Parameters:
- XLEN, 32, data and address width.

Ports:
- clk  in  1  clock; everything updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE with rst low.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_fault  out  1  valid with resp_valid; access was misaligned or illegal.
- load_data  out  XLEN  extended load result; held until the next load response.
- mem_read  out  1  to data-memory read enable.
- mem_write  out  1  to data-memory write enable.
- mem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}.
- mem_wdata  out  XLEN  full word to write.
- mem_rdata  in  XLEN  combinational read data from memory.

## Operation

- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: on req_valid && req_ready, latch we, funct3, addr and wdata. Then decode:
  - Illegal funct3 goes to RESP with fault=1. Loads allow 0, 1, 2, 4, 5. Stores allow 0, 1, 2.
  - Misaligned goes to RESP with fault=1. Halfword is misaligned when addr[0]=1; word when addr[1:0]≠0.
  - Legal load goes to LOAD.
  - SW goes to WRITE with the merge word = wdata.
  - SB/SH go to RMW_RD.
- LOAD: mem_read=1. Capture the extracted mem_rdata into load_data. Go to RESP.
  - Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RMW_RD: mem_read=1. Merge wdata[7:0] or wdata[15:0] into the selected lane of mem_rdata. Register the result as the merge word. Go to WRITE.
- WRITE: mem_write=1, mem_wdata = merge word. Go to RESP.
- RESP: resp_valid=1, and resp_fault reflects the decode result. Go to IDLE.
- A faulting access never asserts mem_read or mem_write.
- mem_read and mem_write are never high in the same cycle.

## Timing

- Let E0 be the accept edge; resp_valid is high in the cycle after the listed edge.
  - Fault: after E0.
  - Load and SW: after E1.
  - SB/SH: after E2.
- req_ready is low from the accept edge until the state returns to IDLE. Maximum throughput is one load per 3 cycles.
- No response backpressure: the consumer must take resp_valid when it is high.
- mem_read, mem_write and req_ready are decoded combinationally from the state and gated by !rst.
- Reset values:
  - State is IDLE.
  - req_ready reads 0 while rst is high and 1 in the first cycle after.
  - resp_valid=0, resp_fault=0, load_data=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation:
  - The transaction is dropped with no response.
  - A write is suppressed if rst is high during WRITE.
  - Memory contents are unchanged by the aborted access.
- req_valid while busy is ignored; the request is not latched.

## Structure

- Package lsu_pkg holds:
  - The funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - The state enum.
  - A misalignment-check function.
- One combinational sub-module, lsu_lane, handles both lane directions:
  - Extract: rdata, funct3, addr[1:0] → extended load value.
  - Merge: rdata, wdata, funct3, addr[1:0] → merged store word.
- The FSM and registers stay in load_store_unit.

## Test plan

Memory model: word 0x10 preset to 0x8899AABB, combinational read, write on posedge.

- Sub-word loads:
  - LB 0x11 → load_data 0xFFFFFFAA, fault 0, resp after E1, no mem_write.
  - LBU 0x13 → 0x00000088.
  - LH 0x10 → 0xFFFFAABB.
  - LHU 0x12 → 0x00008899.
- Stores:
  - SB 0x12 with wdata 0x12345677 → RMW_RD cycle, then write 0x8877AABB to mem_addr 0x10; resp after E2.
  - SH 0x10 with wdata 0x0000CAFE → word 0x8899CAFE.
  - SW 0x10 with wdata 0xDEADBEEF → one write cycle, no mem_read, resp after E1.
- Faults: LW 0x11, SH 0x13 and load funct3=3 each → resp_fault 1 after E0, mem_read/mem_write never high, memory unchanged.
- Reset abort: rst asserted during the WRITE cycle of SW 0x10 → mem_write 0, word stays 0x8899AABB, no resp_valid, req_ready 1 in the first cycle after rst deasserts.
- Back-to-back: req_valid held high with two loads → the second is accepted in the cycle after the first resp_valid, with no lost or duplicated response.
